multicycle_ctrl: RTL
====================

# multicycle_ctrl

Multicycle control FSM for the RV32I core, directly upstream of the ALU. Sequences each instruction through fetch, decode, execute, memory and writeback. Drives the ALU operand selects and 4-bit ALU op code, consumes the ALU flags for branch resolution, and stalls on a single memory ready handshake.

## Interface
- No parameters. Encodings are fixed: ALU op, opcodes, and flags {V,C,N,Z} = flags[3:0].
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous active-low reset
- opcode  in  7  instr[6:0], from instruction register
- funct3  in  3  instr[14:12]
- funct7b5  in  1  instr[30]
- flags  in  4  ALU flags. [0]=Z (res==0), [1]=N (res MSB), [2]=C (borrow: src1<src2 unsigned on SUB), [3]=V (signed overflow on SUB)
- mem_ready  in  1  memory completes the current access this cycle
- pc_write  out  1  load PC from result bus
- adr_src  out  1  memory address: 0=PC, 1=result bus
- mem_write  out  1  store strobe
- ir_write  out  1  capture instruction and old PC
- reg_write  out  1  register-file write enable
- result_src  out  2  result bus: 00=alu_out reg, 01=mem data reg, 10=ALU result direct
- alu_src_a  out  2  src1 select: 00=PC, 01=old PC, 10=rs1, 11=zero
- alu_src_b  out  2  src2 select: 00=rs2, 01=imm, 10=constant 4
- alu_op  out  4  0000 ADD, 0001 SUB, 0010 AND, 0011 OR, 0100 XOR, 0101 SLT, 0110 SRA, 0111 SRL, 1000 SLL, 1001 SLTU
- imm_src  out  3  combinational from opcode: I=000, S=001, B=010, J=011, U=100. 000 for unknown opcodes.
- illegal  out  1  sticky; high while in TRAP

## Operation
- Moore FSM. Outputs not listed for a state default to 0, alu_op defaults to ADD, selects default to 00. The only exceptions are the mem_ready-qualified outputs noted below.
- FETCH: adr_src=0, a=PC, b=4, ADD, result_src=10.
  - ir_write=pc_write=mem_ready.
  - Go to DECODE on mem_ready, else stay.
- DECODE: a=old PC, b=imm, ADD (branch/JAL target into alu_out). Next state by opcode:
  - 0000011 or 0100011 → MEMADR
  - 0110011 → EXEC_R
  - 0010011 → EXEC_I
  - 1100011 → BRANCH
  - 1101111 → JUMP
  - 1100111 → JALR_ADR
  - 0110111 → LUI
  - anything else → TRAP
- MEMADR: a=rs1, b=imm, ADD. Go to MEMREAD if opcode is a load, else MEMWRITE.
- MEMREAD: adr_src=1, result_src=00. Hold until mem_ready, then MEMWB.
- MEMWB: result_src=01, reg_write=1. Then FETCH.
- MEMWRITE: adr_src=1, result_src=00, mem_write=1. mem_write is held until mem_ready, then FETCH.
- EXEC_R: a=rs1, b=rs2, alu_op from funct decode. Then ALUWB.
- EXEC_I: a=rs1, b=imm, alu_op from funct decode. Then ALUWB.
  - For EXEC_I, funct7b5 is used only when funct3=101.
- funct decode by funct3:
  - 000: SUB if R-type and funct7b5, else ADD
  - 001: SLL
  - 010: SLT
  - 011: SLTU
  - 100: XOR
  - 101: SRA if funct7b5, else SRL
  - 110: OR
  - 111: AND
- ALUWB: result_src=00, reg_write=1. Then FETCH.
- BRANCH: a=rs1, b=rs2, SUB, result_src=00. pc_write=taken. Then FETCH.
  - taken by funct3: beq=Z, bne=!Z, blt=N^V, bge=!(N^V), bltu=C, bgeu=!C.
  - funct3 010 or 011 → TRAP, with no pc_write.
- JALR_ADR: a=rs1, b=imm, ADD. Then JUMP.
  - Target LSB is not cleared and misaligned targets are not checked.
- JUMP: a=old PC, b=4, ADD, result_src=00, pc_write=1. Then ALUWB (writes old PC+4 to rd).
- LUI: a=zero, b=imm, ADD. Then ALUWB.
- TRAP: all enables 0, illegal=1. Held until reset.

## Timing
- Reset: state=FETCH at the first edge with rst_n low.
  - During and after reset, all enables are 0 except the mem_ready-qualified FETCH outputs.
  - illegal=0, alu_op=ADD.
- rst_n low mid-instruction aborts it. No further write enable is asserted after the reset edge.
- Cycle counts with zero wait states:
  - load 5
  - store 4
  - R/I-type 4
  - branch 3
  - JAL 4
  - JALR 5
  - LUI 4
- Each cycle with mem_ready=0 in FETCH, MEMREAD or MEMWRITE adds one cycle. No other state samples mem_ready.
- flags are sampled in the BRANCH cycle only, combinationally, from the same-cycle SUB.
- pc_write, reg_write and mem_write are never asserted in the same cycle except pc_write alone.

## Test plan
- ADD x3,x1,x2 (opcode 0110011, f3=000, f7b5=0), mem_ready=1: state sequence FETCH,DECODE,EXEC_R,ALUWB. alu_op=0000 in EXEC_R; reg_write=1 only in cycle 4.
- SUB, SRA, SLTU, ANDI decode: alu_op = 0001, 0110, 1001, 0010 respectively in EXEC_R/EXEC_I.
- Branches with SUB flags:
  - beq with flags=0001: pc_write=1.
  - blt with flags=1010 (N=1, V=1): pc_write=0.
  - bltu with flags=0100: pc_write=1.
  - bgeu with flags=0100: pc_write=0.
- LW with mem_ready low for 3 cycles in FETCH and 2 in MEMREAD: completes in 10 cycles. ir_write pulses once; reg_write pulses once in MEMWB with result_src=01.
- SW with mem_ready=0 for 2 cycles: mem_write high for 3 consecutive cycles with adr_src=1, then FETCH.
- Opcode 0000000: DECODE→TRAP, illegal=1 stays high with no enables. Assert rst_n=0 mid-load in MEMREAD: the next cycle is FETCH with illegal=0 and reg_write=0.

Source files
------------

// File: rtl/multicycle_ctrl.sv
// Multicycle RV32I control FSM: fetch/decode/execute/memory/writeback sequencing.
// Latency: 3-5 cycles per instruction at zero wait states; outputs are Moore except mem_ready/flag-qualified strobes.
// Backpressure: stalls in FETCH, MEMREAD and MEMWRITE while mem_ready is low.
module multicycle_ctrl (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic [3:0] flags,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       adr_src,
  output logic       mem_write,
  output logic       ir_write,
  output logic       reg_write,
  output logic [1:0] result_src,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [3:0] alu_op,
  output logic [2:0] imm_src,
  output logic       illegal
);

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE,
    S_EXEC_R, S_EXEC_I, S_ALUWB, S_BRANCH, S_JALR_ADR, S_JUMP,
    S_LUI, S_TRAP
  } state_t;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_AND  = 4'b0010;
  localparam logic [3:0] ALU_OR   = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_SLT  = 4'b0101;
  localparam logic [3:0] ALU_SRA  = 4'b0110;
  localparam logic [3:0] ALU_SRL  = 4'b0111;
  localparam logic [3:0] ALU_SLL  = 4'b1000;
  localparam logic [3:0] ALU_SLTU = 4'b1001;

  state_t state, state_nxt;

  logic       flag_z, flag_n, flag_c, flag_v;
  logic       br_taken, br_valid;
  logic [3:0] funct_op;

  assign flag_z = flags[0];
  assign flag_n = flags[1];
  assign flag_c = flags[2];
  assign flag_v = flags[3];

  // funct7b5 selects SUB only for register-register ops; shifts use it in both forms
  always_comb begin
    funct_op = ALU_ADD;
    case (funct3)
      3'b000:  funct_op = (state == S_EXEC_R && funct7b5) ? ALU_SUB : ALU_ADD;
      3'b001:  funct_op = ALU_SLL;
      3'b010:  funct_op = ALU_SLT;
      3'b011:  funct_op = ALU_SLTU;
      3'b100:  funct_op = ALU_XOR;
      3'b101:  funct_op = funct7b5 ? ALU_SRA : ALU_SRL;
      3'b110:  funct_op = ALU_OR;
      default: funct_op = ALU_AND;
    endcase
  end

  always_comb begin
    br_taken = 1'b0;
    br_valid = 1'b1;
    case (funct3)
      3'b000:  br_taken = flag_z;
      3'b001:  br_taken = !flag_z;
      3'b100:  br_taken = flag_n ^ flag_v;
      3'b101:  br_taken = !(flag_n ^ flag_v);
      3'b110:  br_taken = flag_c;
      3'b111:  br_taken = !flag_c;
      default: br_valid = 1'b0;
    endcase
  end

  always_comb begin
    case (opcode)
      OP_LOAD, OP_I, OP_JALR: imm_src = 3'b000;
      OP_STORE:               imm_src = 3'b001;
      OP_BR:                  imm_src = 3'b010;
      OP_JAL:                 imm_src = 3'b011;
      OP_LUI:                 imm_src = 3'b100;
      default:                imm_src = 3'b000;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= S_FETCH;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_FETCH:    if (mem_ready) state_nxt = S_DECODE;
      S_DECODE: begin
        case (opcode)
          OP_LOAD, OP_STORE: state_nxt = S_MEMADR;
          OP_R:              state_nxt = S_EXEC_R;
          OP_I:              state_nxt = S_EXEC_I;
          OP_BR:             state_nxt = S_BRANCH;
          OP_JAL:            state_nxt = S_JUMP;
          OP_JALR:           state_nxt = S_JALR_ADR;
          OP_LUI:            state_nxt = S_LUI;
          default:           state_nxt = S_TRAP;
        endcase
      end
      S_MEMADR:   state_nxt = (opcode == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
      S_MEMREAD:  if (mem_ready) state_nxt = S_MEMWB;
      S_MEMWB:    state_nxt = S_FETCH;
      S_MEMWRITE: if (mem_ready) state_nxt = S_FETCH;
      S_EXEC_R:   state_nxt = S_ALUWB;
      S_EXEC_I:   state_nxt = S_ALUWB;
      S_ALUWB:    state_nxt = S_FETCH;
      S_BRANCH:   state_nxt = br_valid ? S_FETCH : S_TRAP;
      S_JALR_ADR: state_nxt = S_JUMP;
      S_JUMP:     state_nxt = S_ALUWB;
      S_LUI:      state_nxt = S_ALUWB;
      default:    state_nxt = S_TRAP;
    endcase
  end

  always_comb begin
    pc_write   = 1'b0;
    adr_src    = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    reg_write  = 1'b0;
    result_src = 2'b00;
    alu_src_a  = 2'b00;
    alu_src_b  = 2'b00;
    alu_op     = ALU_ADD;
    illegal    = 1'b0;
    case (state)
      S_FETCH: begin
        alu_src_b  = 2'b10;
        result_src = 2'b10;
        ir_write   = mem_ready;
        pc_write   = mem_ready;
      end
      S_DECODE: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b01;
      end
      S_MEMADR, S_JALR_ADR: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
      end
      S_MEMREAD:  adr_src = 1'b1;
      S_MEMWB: begin
        result_src = 2'b01;
        reg_write  = 1'b1;
      end
      S_MEMWRITE: begin
        adr_src   = 1'b1;
        mem_write = 1'b1;
      end
      S_EXEC_R: begin
        alu_src_a = 2'b10;
        alu_op    = funct_op;
      end
      S_EXEC_I: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        alu_op    = funct_op;
      end
      S_ALUWB:    reg_write = 1'b1;
      S_BRANCH: begin
        alu_src_a = 2'b10;
        alu_op    = ALU_SUB;
        pc_write  = br_valid && br_taken;
      end
      S_JUMP: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b10;
        pc_write  = 1'b1;
      end
      S_LUI: begin
        alu_src_a = 2'b11;
        alu_src_b = 2'b01;
      end
      S_TRAP:     illegal = 1'b1;
      default: ;
    endcase
  end

endmodule
